// File: rtl/inv_diffusion_layer_pkg.sv
// -----------------------------------------------------------------------------
// inv_diffusion_layer_pkg
// Shared types and constants for the inverse ASCON linear diffusion layer.
//   type_state        : 5 x 64-bit ASCON state, packed, row 0 in [0].
//   DIFF_ROT_A/B      : per-row rotate-right amounts of the forward layer.
//   INV_DIFF_STEPS    : number of squaring factors making up the inverse.
//   inv_diff_state_e  : FSM states of the iterative inverter.
//   rotr64            : 64-bit rotate right helper.
// -----------------------------------------------------------------------------
package inv_diffusion_layer_pkg;

    localparam int N_ROWS         = 5;
    localparam int INV_DIFF_STEPS = 6;

    typedef logic [N_ROWS-1:0][63:0] type_state;

    localparam logic [5:0] DIFF_ROT_A [0:4] = '{6'd19, 6'd61, 6'd1,  6'd10, 6'd7};
    localparam logic [5:0] DIFF_ROT_B [0:4] = '{6'd28, 6'd39, 6'd6,  6'd17, 6'd41};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } inv_diff_state_e;

    function automatic logic [63:0] rotr64(input logic [63:0] x, input logic [5:0] n);
        logic [127:0] dbl;
        dbl = {x, x} >> n;
        return dbl[63:0];
    endfunction

endpackage

// File: rtl/inv_diffusion_layer_if.sv
// -----------------------------------------------------------------------------
// inv_diffusion_layer_if
// Handshake/data bundle of the inverse diffusion layer.
//   start_i : request, honoured only while not busy
//   inv_i   : diffused state to invert
//   busy_o  : high while iterating
//   done_o  : one-cycle pulse when inv_o is updated
//   inv_o   : recovered pre-diffusion state
// master = requester side, slave = the inverter itself.
// -----------------------------------------------------------------------------
interface inv_diffusion_layer_if;
    import inv_diffusion_layer_pkg::*;

    logic      start_i;
    type_state inv_i;
    logic      busy_o;
    logic      done_o;
    type_state inv_o;

    modport master (
        output start_i,
        output inv_i,
        input  busy_o,
        input  done_o,
        input  inv_o
    );

    modport slave (
        input  start_i,
        input  inv_i,
        output busy_o,
        output done_o,
        output inv_o
    );

endinterface

// File: rtl/inv_diffusion_layer_step.sv
// -----------------------------------------------------------------------------
// inv_diff_step
// Combinational factor F(x) = x ^ (x >>> a*2^k mod 64) ^ (x >>> b*2^k mod 64)
// of the inverse row map.
//   row_i   : 64-bit input row
//   rot_a_i : base rotation a of the row
//   rot_b_i : base rotation b of the row
//   step_i  : factor index k (0..5)
//   row_o   : F(row_i)
// -----------------------------------------------------------------------------
module inv_diff_step
    import inv_diffusion_layer_pkg::*;
(
    input  logic [63:0] row_i,
    input  logic [5:0]  rot_a_i,
    input  logic [5:0]  rot_b_i,
    input  logic [2:0]  step_i,
    output logic [63:0] row_o
);

    // Shifting inside a 6-bit result gives the "mod 64" for free. Some
    // factors degenerate (amount 0 cancels x itself), which is still exact.
    logic [5:0] amt_a;
    logic [5:0] amt_b;

    always_comb begin
        amt_a = rot_a_i << step_i;
        amt_b = rot_b_i << step_i;
        row_o = row_i ^ rotr64(row_i, amt_a) ^ rotr64(row_i, amt_b);
    end

endmodule

// File: rtl/inv_diffusion_layer.sv
// -----------------------------------------------------------------------------
// inv_diffusion_layer
// Iterative inverse of the ASCON linear diffusion layer. Each row map
// S(x) = x ^ (x>>>a) ^ (x>>>b) satisfies S^64 = identity over GF(2), so the
// inverse is S^63 = product of the six factors S^(2^k), k = 0..5.
//   clock_i : clock, rising edge
//   reset_i : asynchronous active-high reset
//   bus     : inv_diffusion_layer_if.slave (start/inv in, busy/done/inv out)
// Optional build macro INV_DIFF_FAST_EN: two factors per cycle (3-cycle run)
// instead of one (6-cycle run). Handshake is identical in both builds.
// -----------------------------------------------------------------------------
module inv_diffusion_layer
    import inv_diffusion_layer_pkg::*;
(
    input  logic                        clock_i,
    input  logic                        reset_i,
    inv_diffusion_layer_if.slave        bus
);

    localparam int N_STEPS = INV_DIFF_STEPS;

`ifdef INV_DIFF_FAST_EN
    localparam logic [2:0] STRIDE = 3'd2;
`else
    localparam logic [2:0] STRIDE = 3'd1;
`endif
    localparam logic [2:0] LAST_CNT = 3'(N_STEPS) - STRIDE;

    inv_diff_state_e state_q, state_d;
    logic [2:0]      cnt_q,   cnt_d;
    type_state       st_q,    st_d;
    type_state       inv_q,   inv_d;
    logic            done_q,  done_d;

    type_state       mid_row;
    type_state       nxt_row;

    // One factor per row per cycle; the fast build cascades factor k+1
    // directly behind factor k.
    genvar gi;
    generate
        for (gi = 0; gi < N_ROWS; gi++) begin : g_row
            inv_diff_step u_step0 (
                .row_i   (st_q[gi]),
                .rot_a_i (DIFF_ROT_A[gi]),
                .rot_b_i (DIFF_ROT_B[gi]),
                .step_i  (cnt_q),
                .row_o   (mid_row[gi])
            );
`ifdef INV_DIFF_FAST_EN
            inv_diff_step u_step1 (
                .row_i   (mid_row[gi]),
                .rot_a_i (DIFF_ROT_A[gi]),
                .rot_b_i (DIFF_ROT_B[gi]),
                .step_i  (cnt_q + 3'd1),
                .row_o   (nxt_row[gi])
            );
`else
            assign nxt_row[gi] = mid_row[gi];
`endif
        end
    endgenerate

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            st_q    <= '0;
            inv_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            inv_q   <= inv_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        inv_d   = inv_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    st_d    = bus.inv_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // start_i is deliberately not looked at here: no restart,
                // no queuing, including on the completing edge.
                st_d  = nxt_row;
                cnt_d = cnt_q + STRIDE;
                if (cnt_q == LAST_CNT) begin
                    inv_d   = nxt_row;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy_o = (state_q == RUN);
    assign bus.done_o = done_q;
    assign bus.inv_o  = inv_q;

endmodule

// File: tb/tb_inv_diffusion_layer.sv
// -----------------------------------------------------------------------------
// tb_inv_diffusion_layer
// Self-checking bench: builds diffused states with an independent forward
// diffusion model, pushes the original state to a scoreboard queue on start,
// and pops/compares when done_o is seen.
// -----------------------------------------------------------------------------
module tb_inv_diffusion_layer;
    import inv_diffusion_layer_pkg::*;

`ifdef INV_DIFF_FAST_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 6;
`endif
    localparam int BUDGET = 30;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    type_state sb_q[$];
    type_state last_result;

    inv_diffusion_layer_if bus ();

    inv_diffusion_layer dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent forward model of the ASCON linear layer.
    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        if (n == 0) return x;
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic type_state diffuse(input type_state x);
        type_state y;
        int ra [5] = '{19, 61, 1, 10, 7};
        int rb [5] = '{28, 39, 6, 17, 41};
        for (int r = 0; r < 5; r++)
            y[r] = x[r] ^ ror(x[r], ra[r]) ^ ror(x[r], rb[r]);
        return y;
    endfunction

    // Drives one request and waits (bounded) for done_o. Returns the cycle
    // count after the accepting edge, inv_o at done, and done_o one cycle later.
    task automatic do_op(input type_state y, input int poke_cycle,
                         output int lat, output type_state obs,
                         output logic done_after, output logic busy_early);
        lat = -1;
        obs = '0;
        done_after = 1'b0;
        @(posedge clk); #1;
        bus.inv_i   = y;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.inv_i   = ~y;  // must already be registered
        busy_early  = bus.busy_o;
        for (int n = 1; n <= BUDGET; n++) begin
            if (n == poke_cycle) begin
                bus.start_i = 1'b1;
                bus.inv_i   = '1;
            end
            @(posedge clk); #1;
            bus.start_i = 1'b0;
            if (bus.done_o) begin
                lat = n;
                obs = bus.inv_o;
                @(posedge clk); #1;
                done_after = bus.done_o;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.inv_o !== '0) begin
            errors++;
            $display("FAIL reset_async: busy=%b done=%b inv=%h required 0/0/0",
                     bus.busy_o, bus.done_o, bus.inv_o);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.inv_o !== '0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b inv=%h required 0/0/0",
                     bus.busy_o, bus.done_o, bus.inv_o);
        end
        $display("reset: busy=%b done=%b", bus.busy_o, bus.done_o);
    endtask

    // One full round trip: X -> diffuse -> DUT -> compare against scoreboard.
    task automatic run_round_trip(input string name, input type_state x, input int poke);
        int        lat;
        type_state obs, exp;
        logic      da, be;
        sb_q.push_back(x);
        do_op(diffuse(x), poke, lat, obs, da, be);
        checks++;
        if (be !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy: busy after accept=%b required 1", name, be);
        end
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL %s_latency: done after %0d cycles required %0d", name, lat, LAT);
        end
        if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s_data: got %h required %h", name, obs, exp);
            end
        end
        checks++;
        if (da !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: done one cycle later=%b required 0", name, da);
        end
        last_result = x;
        $display("%s: lat=%0d inv_o=%h", name, lat, obs);
    endtask

    task automatic test_zero;
        run_round_trip("zero", '0, -1);
    endtask

    task automatic test_ones;
        run_round_trip("ones", '1, -1);
    endtask

    task automatic test_round_trip;
        type_state x;
        x[0] = 64'h78e2cc41faabaa1a;
        x[1] = 64'hbc7a2e775aababf7;
        x[2] = 64'h4b81c0cbbdb5fc1a;
        x[3] = 64'hb22e133e424f0250;
        x[4] = 64'h044d33702433805d;
        run_round_trip("round_trip", x, -1);
    endtask

    task automatic test_single_bits;
        type_state x;
        for (int r = 0; r < 5; r++) begin
            x = '0;
            x[r] = 64'd1 << (r * 13 + 3);
            run_round_trip($sformatf("bit_row%0d", r), x, -1);
        end
    endtask

    task automatic test_random;
        type_state x;
        for (int t = 0; t < 3; t++) begin
            for (int r = 0; r < 5; r++) x[r] = {$urandom, $urandom};
            run_round_trip($sformatf("random%0d", t), x, -1);
        end
    endtask

    task automatic test_busy_ignore;
        type_state x;
        for (int r = 0; r < 5; r++) x[r] = 64'h0123456789abcdef ^ (64'(r) << 60);
        run_round_trip("busy_ignore", x, 2);
        @(posedge clk); #1;
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_idle: busy=%b required 0", bus.busy_o);
        end
    endtask

    task automatic test_back_to_back;
        type_state x, exp;
        logic      b0, b1;
        for (int r = 0; r < 5; r++) x[r] = {$urandom, $urandom};
        sb_q.push_back(x);
        @(posedge clk); #1;
        bus.inv_i   = diffuse(x);
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int n = 1; n <= LAT; n++) begin
            if (n == LAT) bus.start_i = 1'b1;  // sampled on the completing edge
            @(posedge clk); #1;
        end
        bus.start_i = 1'b0;
        checks++;
        if (bus.done_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: done=%b required 1", bus.done_o);
        end
        exp = sb_q.pop_front();
        checks++;
        if (bus.inv_o !== exp) begin
            errors++;
            $display("FAIL b2b_data: got %h required %h", bus.inv_o, exp);
        end
        b0 = bus.busy_o;
        @(posedge clk); #1;
        b1 = bus.busy_o;
        checks++;
        if (b0 !== 1'b0 || b1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ignored: busy=%b,%b required 0,0", b0, b1);
        end
        last_result = x;
        $display("back_to_back: busy after done=%b,%b", b0, b1);
    endtask

    task automatic test_reset_abort;
        type_state y;
        logic      seen;
        for (int r = 0; r < 5; r++) y[r] = {$urandom, $urandom};
        @(posedge clk); #1;
        bus.inv_i   = y;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy: busy=%b required 1", bus.busy_o);
        end
        checks++;
        if (bus.inv_o !== last_result) begin
            errors++;
            $display("FAIL abort_hold: got %h required %h", bus.inv_o, last_result);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.inv_o !== '0) begin
            errors++;
            $display("FAIL abort_reset: busy=%b done=%b inv=%h required 0/0/0",
                     bus.busy_o, bus.done_o, bus.inv_o);
        end
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < LAT + 3; n++) begin
            @(posedge clk); #1;
            if (bus.done_o || bus.busy_o) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: activity after abort=%b required 0", seen);
        end
        $display("reset_abort: busy=%b done=%b", bus.busy_o, bus.done_o);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        last_result = '0;
        bus.start_i = 1'b0;
        bus.inv_i   = '0;
        test_reset();
        test_zero();
        test_ones();
        test_round_trip();
        test_single_bits();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_round_trip();
        test_reset_abort();
        test_round_trip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inv_diffusion_layer.md
Name: inv_diffusion_layer

Overview:
- Sequential inverse of the ASCON linear diffusion layer. It maps a 320-bit state Y = diffusion_layer(X) back to X.
- Used by the permutation self-check and debug path to undo the diffusion step. Also serves as the golden partner in diffusion_layer verification.
- Each row map is Σi(x) = x ^ (x>>>ai) ^ (x>>>bi). Its inverse is Σi^63 = Π(k=0..5) Fi,k, with Fi,k(x) = x ^ (x>>>(ai·2^k mod 64)) ^ (x>>>(bi·2^k mod 64)).
- One factor k is applied to all five rows per cycle, so the result takes 6 iterations.

Parameters:
- N_ROWS, 5, number of 64-bit state rows (fixed by ASCON; not for override).
- N_STEPS, 6, number of squaring factors (log2 64).

Ports:
- clock_i  input  1  system clock, rising edge.
- reset_i  input  1  asynchronous active-high reset.
- start_i  input  1  load inv_i and begin the computation; honoured only when not busy.
- inv_i  input  type_state (5x64)  diffused state to invert.
- busy_o  output  1  high while iterating.
- done_o  output  1  one-cycle pulse when inv_o becomes valid.
- inv_o  output  type_state (5x64)  recovered pre-diffusion state.

Behaviour:
- Clock, reset and polarity: one clock, clock_i. Reset reset_i is asynchronous and active-high.
- Reset values: FSM = IDLE, step counter = 0, internal state register = 0, inv_o = 0, busy_o = 0, done_o = 0.
- FSM states: IDLE, RUN.
- IDLE with start_i=1: register inv_i, set counter = 0, go to RUN. busy_o rises the next cycle.
- RUN, every cycle: state[i] <= Fi,k(state[i]) for i = 0..4, with k = counter. Counter increments.
- RUN with counter == N_STEPS-1: apply the last factor, return to IDLE, and assert done_o for exactly one cycle. On that same edge, inv_o is updated with the final state.
- Latency: start_i sampled at edge 0 gives done_o and valid inv_o after edge 6 (default build).
- inv_o holds its value until the next completed operation. It is not cleared by a new start.
- Rotation amounts (a,b) per row, all rotate-right:
  - row 0: (19,28)
  - row 1: (61,39)
  - row 2: (1,6)
  - row 3: (10,17)
  - row 4: (7,41)
- Per-step amounts are a·2^k mod 64. Some factors collapse to a single rotation (e.g. row 0, k=5: rotate by 32). This is correct behaviour, not a special case.
- start_i while busy_o=1: ignored. No restart and no queuing.
- start_i in the same cycle that done_o is asserted: FSM is in IDLE after that edge, so start_i must be asserted again next cycle. No back-to-back acceptance.
- reset_i asserted mid-RUN: immediate return to the reset values listed above. The partial result is discarded and done_o is never pulsed.
- The operation is purely linear over GF(2):
  - all-zero input gives all-zero output;
  - all-ones row input gives all-ones row output.

Optional Feature:
- Macro: INV_DIFF_FAST_EN.
- Defined: two factors (k and k+1) are applied per cycle as a combinational cascade. The counter steps by 2, the run takes 3 cycles, and done_o/valid inv_o arrive after edge 3.
- Undefined: one factor per cycle, 6-cycle latency as above.
- Handshake, reset and hold semantics are identical in both builds.

Decomposition:
- Add to ascon_pack:
  - constants DIFF_ROT_A[0:4] = {19,61,1,10,7} and DIFF_ROT_B[0:4] = {28,39,6,17,41};
  - constant INV_DIFF_STEPS = 6;
  - an enum type for the FSM states.
- type_state is reused unchanged.
- One natural sub-module, inv_diff_step:
  - combinational;
  - inputs: one 64-bit row, the row's two base amounts, step index k;
  - output: Fi,k(row).
- Instantiate inv_diff_step five times in the default build, and ten times when INV_DIFF_FAST_EN is defined.

Test Plan:
- Reset during idle: reset_i pulse -> inv_o = 0, busy_o = 0, done_o = 0.
- Zero vector: start with inv_i = all 0x0000000000000000 -> after 6 cycles done_o = 1 for one cycle, inv_o all zero.
- All-ones vector: inv_i = all 0xFFFFFFFFFFFFFFFF -> inv_o = all 0xFFFFFFFFFFFFFFFF.
- Round trip:
  - stimulus: X = {78e2cc41faabaa1a, bc7a2e775aababf7, 4b81c0cbbdb5fc1a, b22e133e424f0250, 044d33702433805d} through a diffusion_layer instance, with its output driven into inv_i;
  - required response: inv_o == X exactly, done_o high on cycle 6 only.
- Busy and reset abort:
  - start_i pulsed again at cycle 2 -> ignored, result unchanged, still 6 cycles;
  - second run, reset_i asserted at cycle 3 -> busy_o drops immediately, no done_o, inv_o = 0.
- INV_DIFF_FAST_EN build: repeat the round-trip scenario -> identical inv_o, done_o on cycle 3.
